// File: rtl/dtw_ctrl_axil_master.sv
// AXI4-Lite initiator for the DTW accelerator register slave (CR/SR/REF_LEN).
// Accepts one command at a time and returns a single response:
//   op 00 = write, op 01/11 = read, op 10 = poll a register until a masked match.
// A poll re-reads the register with POLL_GAP idle cycles between reads.
// It gives up with rsp_timeout after POLL_MAX reads without a match.
// A slave error on any read ends the poll at once.
module dtw_ctrl_axil_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 5,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int POLL_GAP           = 4,
   parameter int POLL_MAX           = 1024
) (
   input  logic                            clk,
   input  logic                            aresetn,
   // command / response
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [1:0]                      cmd_op,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_mask,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic                            rsp_timeout,
   // AXI4-Lite master
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                      m_axi_awprot,
   output logic                            m_axi_awvalid,
   input  logic                            m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                            m_axi_wvalid,
   input  logic                            m_axi_wready,
   input  logic [1:0]                      m_axi_bresp,
   input  logic                            m_axi_bvalid,
   output logic                            m_axi_bready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                      m_axi_arprot,
   output logic                            m_axi_arvalid,
   input  logic                            m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                      m_axi_rresp,
   input  logic                            m_axi_rvalid,
   output logic                            m_axi_rready
);

   localparam int AW    = C_M_AXI_ADDR_WIDTH;
   localparam int DW    = C_M_AXI_DATA_WIDTH;
   localparam int CNT_W = $clog2(POLL_MAX + 1);
   localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   localparam logic [1:0] OP_WRITE  = 2'b00;
   localparam logic [1:0] OP_POLL   = 2'b10;
   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR, ST_WB, ST_RD, ST_RR, ST_CHK, ST_GAP, ST_RSP
   } state_t;

   // True when every bit selected by mask agrees between value and match.
   function automatic logic masked_match(input logic [DW-1:0] value,
                                         input logic [DW-1:0] match,
                                         input logic [DW-1:0] mask);
      return ((value ^ match) & mask) == {DW{1'b0}};
   endfunction

   state_t            state_r;
   logic [AW-1:0]     addr_r;
   logic [DW-1:0]     data_r;
   logic [DW-1:0]     mask_r;
   logic              poll_r;
   logic [DW-1:0]     rdata_r;
   logic [1:0]        rresp_r;
   logic              aw_done_r;
   logic              w_done_r;
   logic [CNT_W-1:0]  poll_cnt_r;
   logic [GAP_W-1:0]  gap_cnt_r;

   logic              cmd_ready_r;
   logic              awvalid_r;
   logic              wvalid_r;
   logic              bready_r;
   logic              arvalid_r;
   logic              rready_r;
   logic              rsp_valid_r;
   logic [DW-1:0]     rsp_rdata_r;
   logic [1:0]        rsp_resp_r;
   logic              rsp_timeout_r;

   logic              aw_hs_s;
   logic              w_hs_s;
   logic              match_s;
   logic              poll_limit_s;
   logic              gap_last_s;

   assign aw_hs_s      = awvalid_r & m_axi_awready;
   assign w_hs_s       = wvalid_r & m_axi_wready;
   assign match_s      = masked_match(rdata_r, data_r, mask_r);
   assign poll_limit_s = (poll_cnt_r == CNT_W'(POLL_MAX));
   assign gap_last_s   = (gap_cnt_r == GAP_W'(POLL_GAP - 1));

   assign cmd_ready     = cmd_ready_r;
   assign rsp_valid     = rsp_valid_r;
   assign rsp_rdata     = rsp_rdata_r;
   assign rsp_resp      = rsp_resp_r;
   assign rsp_timeout   = rsp_timeout_r;
   assign m_axi_awaddr  = addr_r;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_r;
   assign m_axi_wdata   = data_r;
   assign m_axi_wstrb   = {(DW/8){1'b1}};
   assign m_axi_wvalid  = wvalid_r;
   assign m_axi_bready  = bready_r;
   assign m_axi_araddr  = addr_r;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_r;
   assign m_axi_rready  = rready_r;

   // Command sequencer: drives every AXI channel and the response port from registers.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_r       <= ST_IDLE;
         addr_r        <= '0;
         data_r        <= '0;
         mask_r        <= '0;
         poll_r        <= 1'b0;
         rdata_r       <= '0;
         rresp_r       <= 2'b00;
         aw_done_r     <= 1'b0;
         w_done_r      <= 1'b0;
         poll_cnt_r    <= '0;
         gap_cnt_r     <= '0;
         cmd_ready_r   <= 1'b1;
         awvalid_r     <= 1'b0;
         wvalid_r      <= 1'b0;
         bready_r      <= 1'b0;
         arvalid_r     <= 1'b0;
         rready_r      <= 1'b0;
         rsp_valid_r   <= 1'b0;
         rsp_rdata_r   <= '0;
         rsp_resp_r    <= 2'b00;
         rsp_timeout_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cmd_ready_r <= 1'b0;
                  addr_r      <= cmd_addr;
                  data_r      <= cmd_wdata;
                  mask_r      <= cmd_mask;
                  poll_r      <= (cmd_op == OP_POLL);
                  poll_cnt_r  <= '0;
                  if (cmd_op == OP_WRITE) begin
                     awvalid_r <= 1'b1;
                     wvalid_r  <= 1'b1;
                     aw_done_r <= 1'b0;
                     w_done_r  <= 1'b0;
                     state_r   <= ST_WR;
                  end else begin
                     arvalid_r <= 1'b1;
                     state_r   <= ST_RD;
                  end
               end else begin
                  cmd_ready_r <= 1'b1;
               end
            end
            ST_WR: begin
               // Address and data handshakes may complete in either order or together.
               if (aw_hs_s) begin
                  awvalid_r <= 1'b0;
                  aw_done_r <= 1'b1;
               end
               if (w_hs_s) begin
                  wvalid_r <= 1'b0;
                  w_done_r <= 1'b1;
               end
               if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                  bready_r <= 1'b1;
                  state_r  <= ST_WB;
               end
            end
            ST_WB: begin
               if (m_axi_bvalid) begin
                  bready_r      <= 1'b0;
                  rsp_valid_r   <= 1'b1;
                  rsp_rdata_r   <= '0;
                  rsp_resp_r    <= m_axi_bresp;
                  rsp_timeout_r <= 1'b0;
                  state_r       <= ST_RSP;
               end
            end
            ST_RD: begin
               if (m_axi_arready) begin
                  arvalid_r  <= 1'b0;
                  rready_r   <= 1'b1;
                  poll_cnt_r <= poll_cnt_r + CNT_W'(1);
                  state_r    <= ST_RR;
               end
            end
            ST_RR: begin
               if (m_axi_rvalid) begin
                  rready_r <= 1'b0;
                  rdata_r  <= m_axi_rdata;
                  rresp_r  <= m_axi_rresp;
                  if (poll_r) begin
                     state_r <= ST_CHK;
                  end else begin
                     rsp_valid_r   <= 1'b1;
                     rsp_rdata_r   <= m_axi_rdata;
                     rsp_resp_r    <= m_axi_rresp;
                     rsp_timeout_r <= 1'b0;
                     state_r       <= ST_RSP;
                  end
               end
            end
            ST_CHK: begin
               // Error aborts first, then match, then the read budget; otherwise retry.
               if ((rresp_r != RESP_OKAY) || match_s || poll_limit_s) begin
                  rsp_valid_r   <= 1'b1;
                  rsp_rdata_r   <= rdata_r;
                  rsp_resp_r    <= rresp_r;
                  rsp_timeout_r <= (rresp_r == RESP_OKAY) && !match_s;
                  state_r       <= ST_RSP;
               end else if (POLL_GAP == 0) begin
                  arvalid_r <= 1'b1;
                  state_r   <= ST_RD;
               end else begin
                  gap_cnt_r <= '0;
                  state_r   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_last_s) begin
                  arvalid_r <= 1'b1;
                  state_r   <= ST_RD;
               end else begin
                  gap_cnt_r <= gap_cnt_r + GAP_W'(1);
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  cmd_ready_r <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cmd_ready_r <= 1'b1;
               awvalid_r   <= 1'b0;
               wvalid_r    <= 1'b0;
               bready_r    <= 1'b0;
               arvalid_r   <= 1'b0;
               rready_r    <= 1'b0;
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dtw_ctrl_axil_master.sv
// Self-checking bench for dtw_ctrl_axil_master with a configurable-latency
// AXI4-Lite slave and a behavioural command/response reference model.
module tb_dtw_ctrl_axil_master;

   localparam int GAP  = 4;
   localparam int PMAX = 8;

   logic        clk = 1'b0;
   logic        aresetn = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [4:0]  cmd_addr = 5'd0;
   logic [31:0] cmd_wdata = 32'd0;
   logic [31:0] cmd_mask = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;
   logic [4:0]  m_awaddr, m_araddr;
   logic [2:0]  m_awprot, m_arprot;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;
   logic [31:0] m_wdata, m_rdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;

   int checks = 0;
   int errors = 0;

   // slave configuration, written by the tests
   int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
   logic [1:0]  b_resp_cfg = 2'b00;
   logic [33:0] rd_tab [16];
   int          rd_start = 0, rd_n = 0;
   logic        idle_ready = 1'b0;

   // slave / monitor state
   logic [31:0] regs [8];
   int          aw_wait, w_wait, ar_wait, b_left, r_left;
   logic        aw_got, w_got, b_pend, r_pend;
   logic [4:0]  aw_addr_l;
   logic [31:0] w_data_l;
   int          cyc = 0, ar_total = 0, aw_total = 0, w_total = 0, r_hs_cyc = 0;
   int          ar_cyc_log [64];
   logic [4:0]  last_araddr = 5'd0, last_awaddr = 5'd0;
   int          proto_err = 0;
   logic        aw_pend, w_pend, ar_pend;
   int          rsp_seen_cyc = 0;

   dtw_ctrl_axil_master #(
      .C_M_AXI_ADDR_WIDTH(5), .C_M_AXI_DATA_WIDTH(32), .POLL_GAP(GAP), .POLL_MAX(PMAX)
   ) dut (
      .clk(clk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_axi_awaddr(m_awaddr), .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid),
      .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
      .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_bresp(m_bresp),
      .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_araddr(m_araddr),
      .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
      .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid),
      .m_axi_rready(m_rready)
   );

   always #5 clk = ~clk;

   wire aw_hs = m_awvalid && m_awready;
   wire w_hs  = m_wvalid && m_wready;
   wire ar_hs = m_arvalid && m_arready;
   wire wr_both = (aw_got || aw_hs) && (w_got || w_hs);
   wire [4:0]  wr_addr = aw_hs ? m_awaddr : aw_addr_l;
   wire [31:0] wr_data = w_hs ? m_wdata : w_data_l;
   int rd_idx;
   assign rd_idx = ar_total - rd_start;
   wire [33:0] rd_sel = (rd_idx >= 0 && rd_idx < rd_n) ? rd_tab[rd_idx[3:0]]
                                                        : {2'b00, regs[m_araddr[4:2]]};

   assign m_awready = m_awvalid && (aw_wait >= aw_delay);
   assign m_wready  = m_wvalid && (w_wait >= w_delay);
   assign m_arready = m_arvalid && (ar_wait >= ar_delay);
   assign m_bresp   = b_resp_cfg;

   // AXI4-Lite slave model with per-channel programmable latency.
   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_left <= 0; r_left <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         m_bvalid <= 1'b0; m_rvalid <= 1'b0; m_rdata <= 32'd0; m_rresp <= 2'b00;
         aw_addr_l <= 5'd0; w_data_l <= 32'd0;
         for (int i = 0; i < 8; i++) regs[i] <= 32'd0;
      end else begin
         aw_wait <= (m_awvalid && !m_awready) ? aw_wait + 1 : 0;
         w_wait  <= (m_wvalid && !m_wready) ? w_wait + 1 : 0;
         ar_wait <= (m_arvalid && !m_arready) ? ar_wait + 1 : 0;
         if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= m_awaddr; end
         if (w_hs) begin w_got <= 1'b1; w_data_l <= m_wdata; end
         if (m_bvalid && m_bready) m_bvalid <= 1'b0;
         if (wr_both) begin
            aw_got <= 1'b0; w_got <= 1'b0;
            regs[wr_addr[4:2]] <= wr_data;
            if (b_delay == 0) m_bvalid <= 1'b1;
            else begin b_pend <= 1'b1; b_left <= b_delay; end
         end else if (b_pend) begin
            b_left <= b_left - 1;
            if (b_left == 1) begin m_bvalid <= 1'b1; b_pend <= 1'b0; end
         end
         if (m_rvalid && m_rready) m_rvalid <= 1'b0;
         if (ar_hs) begin
            m_rdata <= rd_sel[31:0]; m_rresp <= rd_sel[33:32];
            if (r_delay == 0) m_rvalid <= 1'b1;
            else begin r_pend <= 1'b1; r_left <= r_delay; end
         end else if (r_pend) begin
            r_left <= r_left - 1;
            if (r_left == 1) begin m_rvalid <= 1'b1; r_pend <= 1'b0; end
         end
      end
   end

   // Handshake counters and timestamps used by the tests.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ar_hs) begin
         ar_total <= ar_total + 1; ar_cyc_log[ar_total % 64] <= cyc; last_araddr <= m_araddr;
      end
      if (aw_hs) begin aw_total <= aw_total + 1; last_awaddr <= m_awaddr; end
      if (w_hs) w_total <= w_total + 1;
      if (m_rvalid && m_rready) r_hs_cyc <= cyc;
   end

   // Protocol watch: a valid must stay high until its handshake.
   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
      end else begin
         if ((aw_pend && !m_awvalid) || (w_pend && !m_wvalid) || (ar_pend && !m_arvalid))
            proto_err <= proto_err + 1;
         aw_pend <= m_awvalid && !m_awready;
         w_pend  <= m_wvalid && !m_wready;
         ar_pend <= m_arvalid && !m_arready;
      end
   end

   // Issue one command and collect its response (bounded waits throughout).
   task automatic run_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd,
                          input logic [31:0] mk, input int hold, output logic got,
                          output logic [31:0] rd, output logic [1:0] rs, output logic tm,
                          output logic stable);
      int n;
      got = 1'b0; rd = 32'd0; rs = 2'b00; tm = 1'b0; stable = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_mask = mk;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      @(negedge clk);
      cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_mask = $urandom; cmd_addr = 5'($urandom);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      if (rsp_valid === 1'b1) begin
         got = 1'b1; rsp_seen_cyc = cyc;
         rd = rsp_rdata; rs = rsp_resp; tm = rsp_timeout;
         for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rs || rsp_timeout !== tm)
               stable = 1'b0;
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = idle_ready;
      end
   endtask

   // Reference model: outcome of one command given the slave's scripted read replies.
   function automatic void model_cmd(input logic [1:0] op, input logic [31:0] wd,
                                     input logic [31:0] mk, output logic [31:0] e_rd,
                                     output logic [1:0] e_rs, output logic e_tm,
                                     output int e_reads);
      e_tm = 1'b0;
      if (op == 2'b00) begin
         e_rd = 32'd0; e_rs = b_resp_cfg; e_reads = 0;
      end else if (op != 2'b10) begin
         e_rd = rd_tab[0][31:0]; e_rs = rd_tab[0][33:32]; e_reads = 1;
      end else begin
         e_rd = 32'd0; e_rs = 2'b00; e_reads = 0;
         for (int i = 0; i < PMAX; i++) begin
            e_rd = rd_tab[i][31:0]; e_rs = rd_tab[i][33:32]; e_reads = i + 1;
            if (e_rs != 2'b00) return;
            if ((e_rd & mk) == (wd & mk)) return;
         end
         e_tm = 1'b1;
      end
   endfunction

   logic        g, t, s;
   logic [31:0] d;
   logic [1:0]  r;

   task automatic test_reset();
      #3 aresetn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
      checks++;
      if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_timeout} !== 7'b0) begin
         errors++; $display("FAIL reset_valids got %b exp 0000000",
            {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_timeout});
      end
      checks++;
      if ({rsp_rdata, rsp_resp} !== 34'd0) begin errors++; $display("FAIL reset_rsp got %h exp 0", {rsp_rdata, rsp_resp}); end
      aresetn = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", cmd_ready); end
   endtask

   task automatic test_write();
      int aw0 = aw_total, w0 = w_total;
      aw_delay = 0; w_delay = 2; b_delay = 1; b_resp_cfg = 2'b00;
      run_cmd(2'b00, 5'h08, 32'h000000FA, 32'd0, 1, g, d, r, t, s);
      checks++; if (g !== 1'b1) begin errors++; $display("FAIL wr_rsp_seen got %b exp 1", g); end
      checks++; if (aw_total - aw0 !== 1 || w_total - w0 !== 1) begin
         errors++; $display("FAIL wr_hs_count got aw %0d w %0d exp 1 1", aw_total - aw0, w_total - w0); end
      checks++; if ({r, t, d} !== 35'd0) begin errors++; $display("FAIL wr_rsp got resp %b tmo %b data %h exp 0", r, t, d); end
      checks++; if (regs[2] !== 32'h000000FA || last_awaddr !== 5'h08) begin
         errors++; $display("FAIL wr_slave got reg %h addr %h exp FA 08", regs[2], last_awaddr); end
      checks++; if (m_wstrb !== 4'hF || m_awprot !== 3'b000 || m_arprot !== 3'b000) begin
         errors++; $display("FAIL wr_strb_prot got %h %b %b exp F 000 000", m_wstrb, m_awprot, m_arprot); end
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL wr_rsp_stable got %b exp 1", s); end
      b_resp_cfg = 2'b10;
      run_cmd(2'b00, 5'h0C, 32'h12345678, 32'd0, 0, g, d, r, t, s);
      checks++; if (r !== 2'b10) begin errors++; $display("FAIL wr_bresp_err got %b exp 10", r); end
      b_resp_cfg = 2'b00; w_delay = 0; b_delay = 0;
   endtask

   task automatic test_read();
      rd_start = ar_total; rd_n = 1; rd_tab[0] = {2'b00, 32'h3}; r_delay = 5;
      run_cmd(2'b01, 5'h04, 32'd0, 32'd0, 0, g, d, r, t, s);
      checks++; if (g !== 1'b1 || d !== 32'h3 || r !== 2'b00 || t !== 1'b0) begin
         errors++; $display("FAIL rd_value got %b %h %b %b exp 1 00000003 00 0", g, d, r, t); end
      checks++; if (rsp_seen_cyc !== r_hs_cyc + 1) begin
         errors++; $display("FAIL rd_latency got %0d exp %0d", rsp_seen_cyc, r_hs_cyc + 1); end
      checks++; if (last_araddr !== 5'h04) begin errors++; $display("FAIL rd_addr got %h exp 04", last_araddr); end
      checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rd_back_idle got ready %b valid %b exp 1 0", cmd_ready, rsp_valid); end
      r_delay = 0;
   endtask

   task automatic test_poll_match();
      int a0 = ar_total;
      rd_start = ar_total; rd_n = 3;
      rd_tab[0] = {2'b00, 32'h0}; rd_tab[1] = {2'b00, 32'h5}; rd_tab[2] = {2'b00, 32'h3};
      run_cmd(2'b10, 5'h04, 32'h2, 32'h2, 0, g, d, r, t, s);
      checks++; if (ar_total - a0 !== 3) begin errors++; $display("FAIL poll_ar_count got %0d exp 3", ar_total - a0); end
      checks++; if (g !== 1'b1 || t !== 1'b0 || r !== 2'b00 || d !== 32'h3) begin
         errors++; $display("FAIL poll_match got %b tmo %b %b %h exp 1 0 00 00000003", g, t, r, d); end
   endtask

   task automatic test_poll_timeout();
      int a0 = ar_total;
      rd_start = ar_total; rd_n = 16;
      for (int i = 0; i < 16; i++) rd_tab[i] = {2'b00, 32'($urandom_range(0, 7)) << 1};
      run_cmd(2'b10, 5'h04, 32'h1, 32'h1, 0, g, d, r, t, s);
      checks++; if (ar_total - a0 !== PMAX) begin errors++; $display("FAIL tmo_ar_count got %0d exp %0d", ar_total - a0, PMAX); end
      checks++; if (g !== 1'b1 || t !== 1'b1 || r !== 2'b00 || d !== rd_tab[PMAX-1][31:0]) begin
         errors++; $display("FAIL tmo_rsp got %b tmo %b %b %h exp 1 1 00 %h", g, t, r, d, rd_tab[PMAX-1][31:0]); end
      for (int i = 1; i < PMAX; i++) begin
         checks++;
         if (ar_cyc_log[(a0 + i) % 64] - ar_cyc_log[(a0 + i - 1) % 64] !== GAP + 3) begin
            errors++; $display("FAIL tmo_ar_spacing %0d got %0d exp %0d", i,
               ar_cyc_log[(a0 + i) % 64] - ar_cyc_log[(a0 + i - 1) % 64], GAP + 3);
         end
      end
   endtask

   task automatic test_slverr();
      int a0;
      rd_start = ar_total; rd_n = 1; rd_tab[0] = {2'b10, 32'hDEADBEEF};
      run_cmd(2'b01, 5'h10, 32'd0, 32'd0, 0, g, d, r, t, s);
      checks++; if (r !== 2'b10 || d !== 32'hDEADBEEF || t !== 1'b0) begin
         errors++; $display("FAIL err_read got %b %h %b exp 10 deadbeef 0", r, d, t); end
      a0 = ar_total;
      rd_start = ar_total; rd_n = 2; rd_tab[0] = {2'b10, 32'h2}; rd_tab[1] = {2'b00, 32'h2};
      run_cmd(2'b10, 5'h04, 32'h0, 32'h2, 0, g, d, r, t, s);
      checks++; if (ar_total - a0 !== 1 || r !== 2'b10 || t !== 1'b0 || d !== 32'h2) begin
         errors++; $display("FAIL err_poll got reads %0d %b %b %h exp 1 10 0 00000002", ar_total - a0, r, t, d); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] op; logic [4:0] ad; logic [31:0] wd, mk, e_rd; logic [1:0] e_rs; logic e_tm;
      int e_reads, a0, aw0;
      for (int k = 0; k < 40; k++) begin
         op = 2'($urandom_range(0, 3)); ad = {3'($urandom_range(0, 7)), 2'b00};
         wd = (op == 2'b00) ? $urandom : 32'($urandom_range(0, 15));
         mk = 32'($urandom_range(1, 15)) | ($urandom & 32'hFFFF0000);
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
         ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
         b_resp_cfg = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
         idle_ready = 1'($urandom_range(0, 1)); rsp_ready = idle_ready;
         for (int i = 0; i < 16; i++)
            rd_tab[i] = {(($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00), 32'($urandom_range(0, 15))};
         rd_start = ar_total; rd_n = 16; a0 = ar_total; aw0 = aw_total;
         model_cmd(op, wd, mk, e_rd, e_rs, e_tm, e_reads);
         run_cmd(op, ad, wd, mk, $urandom_range(0, 2), g, d, r, t, s);
         checks++;
         if (g !== 1'b1 || d !== e_rd || r !== e_rs || t !== e_tm || s !== 1'b1) begin
            errors++; $display("FAIL b2b_rsp %0d op %b got %b %h %b %b st %b exp 1 %h %b %b st 1",
               k, op, g, d, r, t, s, e_rd, e_rs, e_tm);
         end
         checks++;
         if (ar_total - a0 !== e_reads || aw_total - aw0 !== ((op == 2'b00) ? 1 : 0)) begin
            errors++; $display("FAIL b2b_count %0d op %b got ar %0d aw %0d exp ar %0d", k, op,
               ar_total - a0, aw_total - aw0, e_reads);
         end
         checks++;
         if ((op == 2'b00) ? (regs[ad[4:2]] !== wd || last_awaddr !== ad) : (last_araddr !== ad)) begin
            errors++; $display("FAIL b2b_addr_data %0d op %b got awaddr %h araddr %h exp %h", k, op,
               last_awaddr, last_araddr, ad);
         end
      end
      idle_ready = 1'b0; rsp_ready = 1'b0;
      aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0; b_resp_cfg = 2'b00;
      checks++; if (proto_err !== 0) begin errors++; $display("FAIL axi_valid_drop got %0d exp 0", proto_err); end
   endtask

   task automatic test_reset_mid();
      int aw0 = aw_total, n = 0;
      aw_delay = 100; w_delay = 100; rd_n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 5'h0C; cmd_wdata = 32'hCAFE0001;
      while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      @(negedge clk); cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1) begin
         errors++; $display("FAIL rstmid_stall got aw %b w %b exp 1 1", m_awvalid, m_wvalid); end
      #2 aresetn = 1'b0;
      #1;
      checks++; if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_async got aw %b w %b rsp %b exp 0 0 0", m_awvalid, m_wvalid, rsp_valid); end
      @(negedge clk); aresetn = 1'b1; aw_delay = 0; w_delay = 0;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1 || m_awvalid !== 1'b0) begin
         errors++; $display("FAIL rstmid_release got ready %b aw %b exp 1 0", cmd_ready, m_awvalid); end
      run_cmd(2'b01, 5'h0C, 32'd0, 32'd0, 0, g, d, r, t, s);
      checks++; if (g !== 1'b1 || d !== 32'd0 || r !== 2'b00 || aw_total !== aw0) begin
         errors++; $display("FAIL rstmid_discard got %b %h %b aw %0d exp 1 0 00 aw %0d", g, d, r, aw_total, aw0); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rd_tab[i] = 34'd0;
      test_reset();
      test_write();
      test_read();
      test_poll_match();
      test_poll_timeout();
      test_slverr();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
